run_scan_ctrl: RTL and testbench

RUN_SCAN_CTRL -- requirements
Module: run_scan_ctrl

---
 rtl/run_scan_ctrl.sv | 141 ++++++++++++++
 tb/tb_run_scan_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/run_scan_ctrl.sv
// rtl/run_scan_ctrl.sv - serial run-of-four detector over 8-bit words, LSB first
// Optional macro RUN_SCAN_CARRY_EN: run history persists across words.
module run_scan_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_count,
    output logic [3:0] out_first,
    output logic       out_hit,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [7:0] r_data;
    logic [2:0] r_idx;
    logic [3:0] r_count;
    logic [3:0] r_first;
    logic       r_hit;
    logic [2:0] r_rl;
    logic       r_lb;
    logic [3:0] r_out_count;
    logic [3:0] r_out_first;
    logic       r_out_hit;

    logic       w_bit;
    logic [2:0] w_rl_nxt;
    logic       w_run_hit;
    logic [3:0] w_count_nxt;
    logic [3:0] w_first_nxt;
    logic       w_hit_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (r_idx == 3'd7) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // rl saturates at 4, so a hit fires on every bit of a run of four or more
    always_comb begin
        w_bit = r_data[r_idx];
        if (r_rl == 3'd0 || w_bit != r_lb) begin
            w_rl_nxt = 3'd1;
        end else if (r_rl == 3'd4) begin
            w_rl_nxt = 3'd4;
        end else begin
            w_rl_nxt = r_rl + 3'd1;
        end
        w_run_hit   = (w_rl_nxt == 3'd4);
        w_count_nxt = r_count + {3'b000, w_run_hit};
        w_first_nxt = (w_run_hit && !r_hit) ? {1'b0, r_idx} : r_first;
        w_hit_nxt   = r_hit | w_run_hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data      <= 8'h00;
            r_idx       <= 3'd0;
            r_count     <= 4'd0;
            r_first     <= 4'hF;
            r_hit       <= 1'b0;
            r_rl        <= 3'd0;
            r_lb        <= 1'b0;
            r_out_count <= 4'd0;
            r_out_first <= 4'hF;
            r_out_hit   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_data  <= in_data;
                        r_idx   <= 3'd0;
                        r_count <= 4'd0;
                        r_first <= 4'hF;
                        r_hit   <= 1'b0;
`ifdef RUN_SCAN_CARRY_EN
                        r_rl    <= r_rl;
`else
                        r_rl    <= 3'd0;
`endif
                    end
                end
                S_SHIFT: begin
                    r_rl    <= w_rl_nxt;
                    r_lb    <= w_bit;
                    r_idx   <= r_idx + 3'd1;
                    r_count <= w_count_nxt;
                    r_first <= w_first_nxt;
                    r_hit   <= w_hit_nxt;
                    // published results change only when a word completes
                    if (r_idx == 3'd7) begin
                        r_out_count <= w_count_nxt;
                        r_out_first <= w_first_nxt;
                        r_out_hit   <= w_hit_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_count = r_out_count;
    assign out_first = r_out_first;
    assign out_hit   = r_out_hit;
    assign state_o   = r_state;

endmodule

// File: tb/tb_run_scan_ctrl.sv
// tb/tb_run_scan_ctrl.sv - self-checking bench for run_scan_ctrl
module tb_run_scan_ctrl;

`ifdef RUN_SCAN_CARRY_EN
    localparam bit CARRY = 1'b1;
`else
    localparam bit CARRY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_count;
    logic [3:0] out_first;
    logic       out_hit;
    logic [1:0] state_o;

    run_scan_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_first (out_first),
        .out_hit   (out_hit),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         cnt;
        int         first;
        int         hit;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;
    bit hist[$];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // hit at bit k whenever the last four bits seen (this word, or all since reset with carry) are equal
    task automatic model_word(input logic [7:0] d, output int cnt, output int first, output int hit);
        cnt = 0; first = 15; hit = 0;
        if (!CARRY) hist.delete();
        for (int k = 0; k < 8; k++) begin
            hist.push_back(d[k]);
            if (hist.size() > 4) void'(hist.pop_front());
            if (hist.size() == 4 && hist[0] == hist[1] && hist[1] == hist[2] && hist[2] == hist[3]) begin
                cnt++;
                if (hit == 0) first = k;
                hit = 1;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        chk("rst_state", int'(state_o), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_count", int'(out_count), 0);
        chk("rst_first", int'(out_first), 15);
        chk("rst_hit", int'(out_hit), 0);
        rst = 1'b0;
        hist.delete();
    endtask

    task automatic offer(input logic [7:0] d);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("offer_ready_timeout", int'(n < 20), 1);
        in_valid = 1'b1; in_data = d;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = 8'($urandom);
    endtask

    task automatic finish_word(input string name, input int ec, input int ef, input int eh, input int hold);
        int lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        chk({name, "_latency"}, lat, 8);
        chk({name, "_count"}, int'(out_count), ec);
        chk({name, "_first"}, int'(out_first), ef);
        chk({name, "_hit"}, int'(out_hit), eh);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({name, "_hold_valid"}, int'(out_valid), 1);
            chk({name, "_hold_count"}, int'(out_count), ec);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({name, "_back_idle"}, int'(state_o), 0);
        chk({name, "_held_first"}, int'(out_first), ef);
    endtask

    initial begin
        vec_t vecs[8];
        int   ec, ef, eh;
        logic [7:0] d;

        vecs[0] = '{8'h0F, 2, 3, 1};
        vecs[1] = '{8'hFF, 5, 3, 1};
        vecs[2] = '{8'h55, 0, 15, 0};
        vecs[3] = '{8'h00, 5, 3, 1};
        vecs[4] = '{8'h18, 0, 15, 0};
        vecs[5] = '{8'h87, 1, 6, 1};
        vecs[6] = '{8'hF0, 2, 3, 1};
        vecs[7] = '{8'hE1, 1, 4, 1};

        for (int v = 0; v < 8; v++) begin
            do_reset();
            offer(vecs[v].data);
            finish_word($sformatf("vec%0d", v), vecs[v].cnt, vecs[v].first, vecs[v].hit, v % 3);
        end

        // F0 then FF: second word sees the carried run only with carry enabled
        do_reset();
        offer(8'hF0);
        finish_word("f0", 2, 3, 1, 0);
        offer(8'hFF);
        finish_word("ff_after_f0", CARRY ? 8 : 5, CARRY ? 0 : 3, 1, 0);

        // result held in DONE while a new word is already offered
        do_reset();
        model_word(8'h0F, ec, ef, eh);
        offer(8'h0F);
        while (!out_valid && n_total < 100000) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b1; in_data = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_count", int'(out_count), 2);
            chk("stall_first", int'(out_first), 3);
            chk("stall_in_ready", int'(in_ready), 0);
            chk("stall_state", int'(state_o), 2);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("leave_done_not_accepted", int'(state_o), 0);
        chk("leave_done_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("accept_first_idle_edge", int'(state_o), 1);
        model_word(8'hFF, ec, ef, eh);
        finish_word("after_stall", ec, ef, eh, 0);

        // reset in the middle of a word
        do_reset();
        offer(8'hAA);
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("mid_shift_state", int'(state_o), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_state", int'(state_o), 0);
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_in_ready", int'(in_ready), 1);
        rst = 1'b0;
        hist.delete();
        offer(8'h0F);
        finish_word("post_rst", 2, 3, 1, 0);

        // randomized words against the reference model
        do_reset();
        for (int r = 0; r < 40; r++) begin
            d = 8'($urandom);
            if (r % 4 == 0) d = {$urandom_range(0, 1) ? 4'hF : 4'h0, d[3:0]};
            model_word(d, ec, ef, eh);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            offer(d);
            finish_word($sformatf("rand%0d_%02h", r, d), ec, ef, eh, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1);
    end

endmodule
